prog_seq_counter: RTL and testbench

PROG_SEQ_COUNTER -- requirements
Module: prog_seq_counter

---
 rtl/prog_seq_counter.sv | 108 ++++++++++
 tb/tb_prog_seq_counter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prog_seq_counter.sv
// Programmable sequence counter: steps an index through a writable value table,
// forward or reverse, with a runtime-loadable active length and a sticky config error.
module prog_seq_counter #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             len_wr,
  input  logic [AW:0]      len_data,
  output logic [WIDTH-1:0] out,
  output logic [AW-1:0]    idx,
  output logic             wrap,
  output logic             err
);

  localparam int LEN_RST = (2 * WIDTH < DEPTH) ? 2 * WIDTH : DEPTH;

  // Johnson-counter pattern; entries past the Johnson run start out zero.
  function automatic logic [WIDTH-1:0] init_val(input int i);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (32'd1 << WIDTH) - 32'd1;
    if (i >= 2 * WIDTH) begin
      v = '0;
    end else if (i <= WIDTH) begin
      v = (32'd1 << i) - 32'd1;
    end else begin
      v = mask & ~((32'd1 << (i - WIDTH)) - 32'd1);
    end
    return v[WIDTH-1:0];
  endfunction

  logic [WIDTH-1:0] tbl [DEPTH];
  logic [AW:0]      len;
  logic [AW:0]      len_m1;
  logic [AW-1:0]    last;
  logic [AW-1:0]    idx_nxt;
  logic [AW:0]      len_nxt;
  logic             wrap_nxt;
  logic             err_nxt;
  logic             len_ok;
  logic             wr_ok;

  assign len_m1 = len - 1'b1;
  assign last   = len_m1[AW-1:0];
  assign len_ok = len_wr && (len_data != '0) && (int'(len_data) <= DEPTH);
  assign wr_ok  = wr_en && (int'(wr_addr) < DEPTH);
  assign out    = tbl[idx];

  // Priority: valid length load, then restart, then step.
  always_comb begin
    idx_nxt  = idx;
    len_nxt  = len;
    wrap_nxt = 1'b0;
    err_nxt  = err | (len_wr & ~len_ok) | (wr_en & ~wr_ok);
    if (len_ok) begin
      len_nxt = len_data;
      idx_nxt = '0;
    end else if (restart) begin
      idx_nxt = dir ? last : '0;
    end else if (en) begin
      if (!dir) begin
        if (idx == last) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end else begin
        if (idx == '0) begin
          idx_nxt  = last;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      len  <= (AW + 1)'(LEN_RST);
      wrap <= 1'b0;
      err  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= init_val(i);
      end
    end else begin
      idx  <= idx_nxt;
      len  <= len_nxt;
      wrap <= wrap_nxt;
      err  <= err_nxt;
      if (wr_ok) begin
        tbl[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_prog_seq_counter.sv
// Directed bench for prog_seq_counter at default parameters (WIDTH=3, DEPTH=8).
module tb_prog_seq_counter;

  logic       clk = 1'b0;
  logic       rst, en, dir, restart, wr_en, len_wr;
  logic [2:0] wr_addr;
  logic [2:0] wr_data;
  logic [3:0] len_data;
  logic [2:0] out;
  logic [2:0] idx;
  logic       wrap, err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_seq_counter dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .restart(restart),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len_wr(len_wr), .len_data(len_data),
    .out(out), .idx(idx), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input int e_out, input int e_idx,
                           input int e_wrap, input int e_err);
    check({tag, ".out"},  int'(out),  e_out);
    check({tag, ".idx"},  int'(idx),  e_idx);
    check({tag, ".wrap"}, int'(wrap), e_wrap);
    check({tag, ".err"},  int'(err),  e_err);
  endtask

  task automatic idle_inputs();
    en = 0; dir = 0; restart = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    len_wr = 0; len_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  int fwd_out [8] = '{1, 3, 7, 6, 4, 0, 1, 3};
  int fwd_wrp [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int rev_out [6] = '{4, 6, 7, 3, 1, 0};
  int rev_idx [6] = '{5, 4, 3, 2, 1, 0};

  initial begin
    rst = 1;
    idle_inputs();
    step();

    // reset state
    do_reset();
    chk_state("rst", 0, 0, 0, 0);

    // forward Johnson run with wrap after 4
    en = 1; dir = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("fwd%0d.out", i), int'(out), fwd_out[i]);
      check($sformatf("fwd%0d.wrap", i), int'(wrap), fwd_wrp[i]);
    end

    // reverse run from reset
    do_reset();
    en = 1; dir = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("rev%0d.out", i), int'(out), rev_out[i]);
      check($sformatf("rev%0d.idx", i), int'(idx), rev_idx[i]);
      check($sformatf("rev%0d.wrap", i), int'(wrap), (i == 0) ? 1 : 0);
    end

    // custom table, len=3
    do_reset();
    wr_en = 1; wr_addr = 0; wr_data = 5;
    step();
    check("wr0.out", int'(out), 5);
    wr_addr = 1; wr_data = 2; step();
    wr_addr = 2; wr_data = 7; step();
    wr_en = 0;
    len_wr = 1; len_data = 3; en = 1; restart = 1;
    step();
    len_wr = 0; restart = 0;
    chk_state("len3", 5, 0, 0, 0);
    step(); chk_state("len3a", 2, 1, 0, 0);
    step(); chk_state("len3b", 7, 2, 0, 0);
    step(); chk_state("len3c", 5, 0, 1, 0);
    // reverse at len 3 wraps to idx 2; entry 3 (value 7 Johnson) never shows
    dir = 1;
    step(); chk_state("len3r", 7, 2, 1, 0);
    dir = 0;

    // write to the next index while stepping lands on out immediately after
    wr_en = 1; wr_addr = 0; wr_data = 3;
    step(); wr_en = 0;
    chk_state("wrstep", 3, 0, 1, 0);

    // invalid len writes: err sticky, sequence keeps len 6
    do_reset();
    en = 1; dir = 0; len_wr = 1; len_data = 0;
    step(); chk_state("bad0", 1, 1, 0, 1);
    len_data = 9;
    step(); chk_state("bad9", 3, 2, 0, 1);
    len_wr = 0;
    step(); chk_state("badc", 7, 3, 0, 1);
    step(); step();
    chk_state("bade", 4, 5, 0, 1);
    step(); chk_state("badw", 0, 0, 1, 1);
    en = 0;
    step(); chk_state("badh", 0, 0, 0, 1);

    // rst mid-sequence with en and a write pending
    do_reset();
    en = 1; dir = 0;
    step(); step(); step();
    check("pre.out", int'(out), 7);
    rst = 1; wr_en = 1; wr_addr = 0; wr_data = 5;
    step();
    rst = 0; wr_en = 0; en = 0;
    chk_state("rstov", 0, 0, 0, 0);
    en = 1;
    step(); check("rstov1.out", int'(out), 1);
    step(); check("rstov2.out", int'(out), 3);

    // hold then restart reverse
    do_reset();
    en = 1; dir = 0;
    for (int i = 0; i < 4; i++) step();
    check("at6.out", int'(out), 6);
    en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_state($sformatf("hold%0d", i), 6, 4, 0, 0);
    end
    restart = 1; dir = 1; en = 1;
    step();
    restart = 0; en = 0;
    chk_state("rstrt", 4, 5, 0, 0);
    dir = 0; restart = 1; en = 1;
    step();
    restart = 0;
    chk_state("rstrf", 0, 0, 0, 0);

    // len=1: every enabled step is a wrap
    len_wr = 1; len_data = 1;
    step();
    len_wr = 0;
    chk_state("len1", 0, 0, 0, 0);
    dir = 0; step(); chk_state("len1f", 0, 0, 1, 0);
    dir = 1; step(); chk_state("len1r", 0, 0, 1, 0);
    en = 0;  step(); chk_state("len1h", 0, 0, 0, 0);

    // len=DEPTH exposes the zero-filled tail entries
    len_wr = 1; len_data = 8;
    step();
    len_wr = 0; en = 1; dir = 1;
    step(); chk_state("len8r", 0, 7, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
